// File: rtl/fifo_controller_if.sv
// ---------------------------------------------------------------------------
// fifo_controller_if
//
// Purpose:
//   Groups the producer handshake, consumer handshake and storage-array port
//   signals of the FIFO controller into one bundle.
//
// Signals:
//   in_valid / in_ready / in_data     producer side (valid/ready)
//   out_valid / out_ready / out_data  consumer side (valid/ready)
//   mem_write_addr / mem_write_en /
//   mem_din                           storage array write port
//   mem_read_addr / mem_read_en /
//   mem_qout                          storage array read port (zero-cycle read)
//
// Modports:
//   master  the controller itself (drives array ports and handshake replies)
//   slave   the surroundings: producer, consumer and storage array
// ---------------------------------------------------------------------------
interface fifo_controller_if #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 7
);

  // Producer side
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;

  // Consumer side
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;

  // Storage array write port
  logic [ADDR_W-1:0] mem_write_addr;
  logic              mem_write_en;
  logic [WORD_W-1:0] mem_din;

  // Storage array read port
  logic [ADDR_W-1:0] mem_read_addr;
  logic              mem_read_en;
  logic [WORD_W-1:0] mem_qout;

  modport master (
    input  in_valid,
    input  in_data,
    input  out_ready,
    input  mem_qout,
    output in_ready,
    output out_valid,
    output out_data,
    output mem_write_addr,
    output mem_write_en,
    output mem_din,
    output mem_read_addr,
    output mem_read_en
  );

  modport slave (
    output in_valid,
    output in_data,
    output out_ready,
    output mem_qout,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  mem_write_addr,
    input  mem_write_en,
    input  mem_din,
    input  mem_read_addr,
    input  mem_read_en
  );

endinterface : fifo_controller_if

// File: rtl/fifo_controller.sv
// ---------------------------------------------------------------------------
// fifo_controller
//
// Purpose:
//   Pointer and handshake controller that turns a dual-port, zero-cycle-read
//   storage array (instantiated next to this block) into a valid/ready FIFO.
//   Owns the write pointer, read pointer and occupancy count; every other
//   output is combinational from that state and the inputs.
//
// Parameters:
//   WIDTH         element width in bits
//   PARALLELISM   elements per FIFO word (word = PARALLELISM*WIDTH bits)
//   HEIGHT        depth in words, any value >= 2
//   ALMOST_FULL   almost_full  when count >= ALMOST_FULL
//   ALMOST_EMPTY  almost_empty when count <= ALMOST_EMPTY
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset (highest priority)
//   flush         synchronous clear of pointers and count; blocks both
//                 handshakes in the cycle it is asserted
//   bus           fifo_controller_if.master: producer/consumer handshakes
//                 and storage array ports
//   count         current occupancy, 0..HEIGHT
//   full, empty, almost_full, almost_empty
//                 status flags decoded from count
// ---------------------------------------------------------------------------
module fifo_controller #(
  parameter int WIDTH        = 8,
  parameter int PARALLELISM  = 1,
  parameter int HEIGHT       = 128,
  parameter int ALMOST_FULL  = HEIGHT - 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  fifo_controller_if.master           bus,
  output logic [$clog2(HEIGHT+1)-1:0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty
);

  // -------------------------------------------------------------------------
  // Derived sizes and decode constants
  // -------------------------------------------------------------------------
  localparam int WORD_W = PARALLELISM * WIDTH;
  localparam int ADDR_W = $clog2(HEIGHT);
  localparam int CNT_W  = $clog2(HEIGHT + 1);

  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(HEIGHT - 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(HEIGHT);
  localparam logic [CNT_W-1:0]  CNT_AF   = CNT_W'(ALMOST_FULL);
  localparam logic [CNT_W-1:0]  CNT_AE   = CNT_W'(ALMOST_EMPTY);

  // -------------------------------------------------------------------------
  // Helper: advance a pointer by one. HEIGHT need not be a power of two, so
  // the wrap is an explicit compare against the last index instead of
  // relying on the pointer width overflowing.
  // -------------------------------------------------------------------------
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr);
    logic [ADDR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = PTR_ZERO;
    end else begin
      nxt = ptr + PTR_ONE;
    end
    return nxt;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  // -------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------
  logic              full_s;
  logic              empty_s;
  logic              almost_full_s;
  logic              almost_empty_s;
  logic              in_ready_s;
  logic              out_valid_s;
  logic              push_s;
  logic              pop_s;
  logic [WORD_W-1:0] wr_word_s;
  logic [WORD_W-1:0] head_word_s;

  // Status flags decoded straight from the registered count.
  always_comb begin
    full_s         = (count_q == CNT_FULL);
    empty_s        = (count_q == CNT_ZERO);
    almost_full_s  = (count_q >= CNT_AF);
    almost_empty_s = (count_q <= CNT_AE);
  end

  // Handshake decode. Both sides look only at the registered count, so there
  // is no bypass: a full FIFO refuses a push even when a pop happens in the
  // same cycle, and an empty FIFO shows nothing until the cycle after a push.
  // flush masks both handshakes so nothing moves during the clear.
  always_comb begin
    in_ready_s  = !full_s && !flush;
    out_valid_s = !empty_s && !flush;
    push_s      = bus.in_valid && in_ready_s;
    pop_s       = out_valid_s && bus.out_ready;
  end

  // Data paths are pure feed-throughs between the streams and the array.
  always_comb begin
    wr_word_s   = bus.in_data;
    head_word_s = bus.mem_qout;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // Pointer and count update. flush wins over push/pop; rst is applied in
  // the register block and wins over everything. Stored array contents are
  // never touched by a clear.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The write lands in the array at the edge that accepts the push; the read
  // side is combinational, so the head word is whatever sits at rd_ptr.
  assign bus.in_ready       = in_ready_s;
  assign bus.out_valid      = out_valid_s;
  assign bus.out_data       = head_word_s;

  assign bus.mem_write_en   = push_s;
  assign bus.mem_write_addr = wr_ptr_q;
  assign bus.mem_din        = wr_word_s;

  assign bus.mem_read_addr  = rd_ptr_q;
  assign bus.mem_read_en    = out_valid_s;

  assign count              = count_q;
  assign full               = full_s;
  assign empty              = empty_s;
  assign almost_full        = almost_full_s;
  assign almost_empty       = almost_empty_s;

endmodule : fifo_controller

// File: doc/fifo_controller.md
# fifo_controller

Pointer and handshake controller that turns the engine's dual-port, zero-cycle-read FIFO storage array into a valid/ready FIFO. It owns the write and read pointers and the occupancy count, and raises full, empty and threshold flags. It drives the array's write port (write_addr, write_en, din) and read port (read_addr, read_en), and presents the array's combinational qout as the output stream. It sits between a producer stage and a consumer stage of the aggregation datapath; the storage array is instantiated alongside it at the same level.

## Interface
- WIDTH, 8: element width in bits.
- PARALLELISM, 1: elements per FIFO word; word width is PARALLELISM*WIDTH.
- HEIGHT, 128: FIFO depth in words; any value ≥ 2, power of two not required.
- ALMOST_FULL, HEIGHT-2: almost_full asserts when count ≥ ALMOST_FULL.
- ALMOST_EMPTY, 2: almost_empty asserts when count ≤ ALMOST_EMPTY.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of the FIFO contents.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts a word.
- in_data  in  PARALLELISM*WIDTH  producer word.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes the head word.
- out_data  out  PARALLELISM*WIDTH  head word; equals mem_qout.
- mem_write_addr  out  $clog2(HEIGHT)  array write address (write pointer).
- mem_write_en  out  1  array write strobe.
- mem_din  out  PARALLELISM*WIDTH  array write data; equals in_data.
- mem_read_addr  out  $clog2(HEIGHT)  array read address (read pointer).
- mem_read_en  out  1  array read enable; equals out_valid.
- mem_qout  in  PARALLELISM*WIDTH  array combinational read data.
- count  out  $clog2(HEIGHT+1)  current occupancy.
- full, empty, almost_full, almost_empty  out  1 each  status flags, all decoded from count.

## Operation
- Registered state: wr_ptr, rd_ptr, count. All other outputs are combinational from this state and the inputs.
- Handshake outputs:
  - in_ready = !full && !flush.
  - out_valid = !empty && !flush.
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
- Memory port drive:
  - mem_write_en = push; mem_write_addr = wr_ptr; mem_din = in_data.
  - mem_read_addr = rd_ptr; out_data = mem_qout.
- Pointer update:
  - On push, wr_ptr advances by 1 and wraps from HEIGHT-1 to 0.
  - On pop, rd_ptr advances by 1 with the same wrap.
  - Wrap is explicit compare, not natural overflow.
- Count update:
  - push only: +1. pop only: −1. Both or neither: unchanged.
- Flags: full = (count == HEIGHT); empty = (count == 0); almost_full and almost_empty as defined in Interface.
- Priority: rst > flush > push/pop.
  - rst or flush clears wr_ptr, rd_ptr and count to 0.
  - Stored array contents are left untouched.
- No bypass:
  - A word pushed while the FIFO is empty is not visible in the same cycle.
  - When full, no push is accepted even if a pop occurs in the same cycle.
- Values outside the valid window are undefined. out_data is don't-care while out_valid = 0.

## Timing
- Reset values: count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, in_ready = 1 (with flush low), out_valid = 0, mem_write_en = 0, both pointers = 0.
- Latency: a word pushed at edge N is on out_data with out_valid = 1 from cycle N+1. The write lands at edge N and the read is combinational.
- Simultaneous push and pop at 0 < count < HEIGHT: both accepted, count unchanged, both pointers advance.
- Full: in_ready = 0. A pop that cycle drops count to HEIGHT-1, so in_ready = 1 the following cycle.
- Empty: out_valid = 0. A push that cycle gives out_valid = 1 the following cycle.
- Wrap-around: after HEIGHT pushes, wr_ptr = 0. Data order is preserved across the wrap.
- Flush or reset while words are stored: the FIFO reads empty the next cycle. In the flush cycle itself no handshake is accepted on either side.
- Producer may hold in_valid high under backpressure. The controller never drops or duplicates a word.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with out_ready = 0 -> count = 3, out_data = 0x11 from the cycle after the first push, empty deasserts one cycle after the first push.
- Fill HEIGHT=4: push 4 words -> full = 1, in_ready = 0, a 5th in_valid is held off. Pop one -> in_ready = 1 next cycle, count = 3.
- Steady stream with in_valid = out_ready = 1 for 20 cycles at HEIGHT=4 -> count constant at its level, pointers wrap, output sequence equals input sequence.
- Pop until empty while pushing on alternate cycles -> out_valid follows each push by exactly 1 cycle, count never exceeds 1.
- Assert flush with count = 3 while in_valid = out_ready = 1 -> no mem_write_en that cycle, next cycle count = 0, empty = 1, pointers = 0.
- Thresholds at HEIGHT=8, ALMOST_FULL=6, ALMOST_EMPTY=2 -> almost_empty = 1 for count 0..2, almost_full = 1 for count 6..8; check every transition.
